// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed 7-segment display driver. A prescaler holds each digit for
// REFRESH_DIV clock cycles. The digit index then advances round-robin over
// N_DIGITS digits. A newly loaded value waits in a pending register until the
// scan wraps back to digit 0, so a frame never shows a mix of old and new
// digits.
//
// Parameters
//   N_DIGITS    number of multiplexed digits (2..8)
//   REFRESH_DIV clock cycles each digit stays enabled (>= 2)
//   ACTIVE_LOW  1 inverts o_7seg and o_digit_en (common-anode boards)
//
// Ports
//   i_clk       clock; all state updates on its rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        scan enable; when low the display is blanked and the scan freezes
//   i_load      single-cycle strobe that captures i_value into the pending register
//   i_value     hex nibbles; nibble k drives digit k (digit 0 = LSB nibble)
//   i_blank_lz  leading-zero blanking enable
//   o_7seg      segment drive {g,f,e,d,c,b,a}
//   o_digit_en  one-hot digit enable
//   o_pending   a loaded value is waiting for the frame boundary
//   o_frame     one-cycle pulse after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_7seg,
  output logic [N_DIGITS-1:0]   o_digit_en,
  output logic                  o_pending,
  output logic                  o_frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

  // Hex nibble to segment pattern {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // State registers and their next-state values
  logic [PW-1:0]       presc_q,    presc_d;
  logic [IW-1:0]       idx_q,      idx_d;
  logic [VW-1:0]       pend_val_q, pend_val_d;
  logic                pend_q,     pend_d;
  logic [VW-1:0]       disp_q,     disp_d;
  logic                frame_q,    frame_d;
  logic [6:0]          seg_q,      seg_d;
  logic [N_DIGITS-1:0] dig_q,      dig_d;

  // Decoded scan events and digit selection
  logic       tick_s;
  logic       wrap_s;
  logic       xfer_s;
  logic [3:0] cur_nib_s;
  logic       upper_nz_s;
  logic       blank_s;

  // Scan events: a tick ends the current digit, a wrap tick ends the frame.
  // Both are gated by i_en, so nothing advances or transfers while disabled.
  always_comb begin
    tick_s = i_en && (presc_q == PRESC_MAX);
    wrap_s = tick_s && (idx_q == IDX_MAX);
    xfer_s = wrap_s && pend_q;
  end

  // Prescaler and digit index next-state; both hold while i_en is low.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (i_en) begin
      if (tick_s) begin
        presc_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
      idx_d   = idx_q;
    end
  end

  // Pending/display double buffer. On a wrap tick the old pending value moves
  // to the display register first. A load in the same cycle then refills the
  // pending register, which keeps o_pending set.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    disp_d     = disp_q;
    frame_d    = wrap_s;
    if (xfer_s) begin
      disp_d = pend_val_q;
      pend_d = 1'b0;
    end else begin
      disp_d = disp_q;
    end
    if (i_load) begin
      pend_val_d = i_value;
      pend_d     = 1'b1;
    end else begin
      pend_val_d = pend_val_q;
    end
  end

  // Selected digit nibble and leading-zero detection over nibble idx and above.
  always_comb begin
    cur_nib_s  = disp_q[4*idx_q +: 4];
    upper_nz_s = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k >= int'(idx_q)) begin
        upper_nz_s = upper_nz_s | (|disp_q[4*k +: 4]);
      end else begin
        upper_nz_s = upper_nz_s;
      end
    end
    // Digit 0 is never blanked, so an all-zero value still shows a single 0.
    blank_s = i_blank_lz && (idx_q != '0) && !upper_nz_s;
  end

  // Output pattern for the current index; registered, so it trails idx by 1.
  always_comb begin
    seg_d = 7'h00;
    dig_d = '0;
    if (i_en) begin
      dig_d = N_DIGITS'(1) << idx_q;
      if (blank_s) begin
        seg_d = 7'h00;
      end else begin
        seg_d = hex_to_seg(cur_nib_s);
      end
    end else begin
      seg_d = 7'h00;
      dig_d = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      disp_q     <= '0;
      frame_q    <= 1'b0;
      seg_q      <= 7'h00;
      dig_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  // Board polarity applied after the register. In reset the registers are 0,
  // so the pins show "off" in either polarity.
  always_comb begin
    if (ACTIVE_LOW) begin
      o_7seg     = ~seg_q;
      o_digit_en = ~dig_q;
    end else begin
      o_7seg     = seg_q;
      o_digit_en = dig_q;
    end
    o_pending = pend_q;
    o_frame   = frame_q;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Two instances share one stimulus stream: one active-high and one active-low
// (N_DIGITS=4, REFRESH_DIV=4). The reference model tracks the number of enabled
// cycles modulo one frame. It derives the digit from division, and it keeps the
// pending/display values as plain variables.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FRM = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blz;

  logic [6:0]  o_7seg,  al_7seg;
  logic [3:0]  o_dig,   al_dig;
  logic        o_pend,  al_pend;
  logic        o_frame, al_frame;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_c;
  logic [15:0] m_pval;
  logic [15:0] m_disp;
  logic        m_pend;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_pend;
  logic        exp_frame;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_value(value),
    .i_blank_lz(blz), .o_7seg(o_7seg), .o_digit_en(o_dig), .o_pending(o_pend),
    .o_frame(o_frame));

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_al (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_value(value),
    .i_blank_lz(blz), .o_7seg(al_7seg), .o_digit_en(al_dig), .o_pending(al_pend),
    .o_frame(al_frame));

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [15:0] v, input int k, input logic bl);
    logic [15:0] hi;
    hi = v >> (4 * k);
    if (bl && k > 0 && hi == 16'h0000) return 7'h00;
    return seg_tbl[hi[3:0]];
  endfunction

  task automatic model_reset();
    m_c       = 0;
    m_pval    = 16'h0000;
    m_disp    = 16'h0000;
    m_pend    = 1'b0;
    exp_seg   = 7'h00;
    exp_dig   = 4'h0;
    exp_pend  = 1'b0;
    exp_frame = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then let the clock tick.
  task automatic step();
    int  d;
    bit  wrap;
    if (en) begin
      d       = m_c / DIV;
      exp_dig = 4'(1 << d);
      exp_seg = model_seg(m_disp, d, blz);
    end else begin
      exp_dig = 4'h0;
      exp_seg = 7'h00;
    end
    wrap      = en && (m_c == FRM - 1);
    exp_frame = wrap;
    if (wrap && m_pend) begin
      m_disp = m_pval;
      m_pend = 1'b0;
    end
    if (load) begin
      m_pval = value;
      m_pend = 1'b1;
    end
    if (en) m_c = (m_c + 1) % FRM;
    exp_pend = m_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0000; blz = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({o_7seg, o_dig, o_pend, o_frame} !== 13'h0) begin
      errors++;
      $display("FAIL reset_async: got seg=%h dig=%b pend=%b frame=%b expected all 0",
               o_7seg, o_dig, o_pend, o_frame);
    end
    checks++;
    if ({al_7seg, al_dig, al_pend, al_frame} !== {7'h7F, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async_al: got seg=%h dig=%b expected seg=7f dig=1111", al_7seg, al_dig);
    end
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_7seg, o_dig, o_pend, o_frame} !== 13'h0) begin
      errors++;
      $display("FAIL reset_held: got seg=%h dig=%b pend=%b frame=%b expected all 0",
               o_7seg, o_dig, o_pend, o_frame);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_default();
    int frames = 0;
    en = 1'b1; load = 1'b0; blz = 1'b0;
    for (int i = 0; i < 2 * FRM; i++) begin
      step();
      if (o_frame) frames++;
      checks++;
      if ({o_7seg, o_dig, o_pend, o_frame} !== {exp_seg, exp_dig, exp_pend, exp_frame}) begin
        errors++;
        $display("FAIL scan_default cyc%0d: got seg=%h dig=%b pend=%b frame=%b expected seg=%h dig=%b pend=%b frame=%b",
                 i, o_7seg, o_dig, o_pend, o_frame, exp_seg, exp_dig, exp_pend, exp_frame);
      end
    end
    checks++;
    if (frames != 2) begin
      errors++;
      $display("FAIL scan_frame_count: got %0d expected 2", frames);
    end
  endtask

  task automatic test_load(input string tag, input logic [15:0] v, input logic bl, input int cycles);
    blz = bl; value = v; load = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      load = 1'b0;
      checks++;
      if ({o_7seg, o_dig, o_pend, o_frame} !== {exp_seg, exp_dig, exp_pend, exp_frame}) begin
        errors++;
        $display("FAIL %s cyc%0d: got seg=%h dig=%b pend=%b frame=%b expected seg=%h dig=%b pend=%b frame=%b",
                 tag, i, o_7seg, o_dig, o_pend, o_frame, exp_seg, exp_dig, exp_pend, exp_frame);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    while (m_c != 6) step();
    checks++;
    test_load("load_12af", 16'h12AF, 1'b0, 3 * FRM);
    if (m_disp !== 16'h12AF || o_pend !== 1'b0) begin
      errors++;
      $display("FAIL load_12af_final: got pend=%b expected pend=0 with 12af shown", o_pend);
    end
  endtask

  task automatic test_blank_lz();
    test_load("blank_on", 16'h0050, 1'b1, 3 * FRM);
    test_load("blank_off", 16'h0050, 1'b0, 2 * FRM);
    test_load("blank_zero", 16'h0000, 1'b1, 2 * FRM);
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    value = 16'h1111; load = 1'b1; step();
    value = 16'h2222; step();
    load = 1'b0;
    test_load("b2b_2222", 16'h2222, 1'b0, 2 * FRM);
    value = 16'h3456; load = 1'b1; step(); load = 1'b0;
    while (m_c != FRM - 1 && guard < 2 * FRM) begin step(); guard++; end
    value = 16'h789A; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (o_pend !== 1'b1 || o_frame !== 1'b1) begin
      errors++;
      $display("FAIL load_on_wrap: got pend=%b frame=%b expected pend=1 frame=1", o_pend, o_frame);
    end
    test_load("after_wrap_load", 16'h789A, 1'b0, 2 * FRM);
  endtask

  task automatic test_enable_gap();
    for (int pass = 0; pass < 2; pass++) begin
      while (m_c % DIV != 1 + pass) step();
      en = 1'b0;
      value = 16'hC0DE; load = (pass == 0);
      for (int i = 0; i < 10 + 2 * FRM; i++) begin
        if (i == 10) en = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({o_7seg, o_dig, o_pend, o_frame} !== {exp_seg, exp_dig, exp_pend, exp_frame}) begin
          errors++;
          $display("FAIL en_gap p%0d cyc%0d: got seg=%h dig=%b pend=%b frame=%b expected seg=%h dig=%b pend=%b frame=%b",
                   pass, i, o_7seg, o_dig, o_pend, o_frame, exp_seg, exp_dig, exp_pend, exp_frame);
        end
        checks++;
        if ({al_7seg, al_dig} !== ~{exp_seg, exp_dig}) begin
          errors++;
          $display("FAIL en_gap_al p%0d cyc%0d: got seg=%h dig=%b expected seg=%h dig=%b",
                   pass, i, al_7seg, al_dig, ~exp_seg, ~exp_dig);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    value = 16'hABCD; load = 1'b1; step(); load = 1'b0;
    checks++;
    if (o_pend !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending: got %b expected 1", o_pend);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o_7seg, o_dig, o_pend, o_frame} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset: got seg=%h dig=%b pend=%b frame=%b expected all 0",
               o_7seg, o_dig, o_pend, o_frame);
    end
    checks++;
    if ({al_7seg, al_dig, al_pend} !== {7'h7F, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_al: got seg=%h dig=%b pend=%b expected seg=7f dig=1111 pend=0",
               al_7seg, al_dig, al_pend);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_load("post_reset", 16'h0000, 1'b0, 0);
    for (int i = 0; i < 2 * FRM; i++) begin
      step();
      checks++;
      if ({o_7seg, o_dig, o_pend, o_frame} !== {exp_seg, exp_dig, exp_pend, exp_frame}) begin
        errors++;
        $display("FAIL post_reset cyc%0d: got seg=%h dig=%b pend=%b frame=%b expected seg=%h dig=%b pend=%b frame=%b",
                 i, o_7seg, o_dig, o_pend, o_frame, exp_seg, exp_dig, exp_pend, exp_frame);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 6) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      blz   = 1'($urandom_range(0, 1));
      step();
      checks++;
      if ({o_7seg, o_dig, o_pend, o_frame} !== {exp_seg, exp_dig, exp_pend, exp_frame}) begin
        errors++;
        $display("FAIL random cyc%0d: got seg=%h dig=%b pend=%b frame=%b expected seg=%h dig=%b pend=%b frame=%b",
                 i, o_7seg, o_dig, o_pend, o_frame, exp_seg, exp_dig, exp_pend, exp_frame);
      end
      checks++;
      if ({al_7seg, al_dig, al_pend, al_frame} !== {~exp_seg, ~exp_dig, exp_pend, exp_frame}) begin
        errors++;
        $display("FAIL random_al cyc%0d: got seg=%h dig=%b expected seg=%h dig=%b",
                 i, al_7seg, al_dig, ~exp_seg, ~exp_dig);
      end
    end
    load = 1'b0;
    en   = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_default();
    test_load_mid_frame();
    test_blank_lz();
    test_back_to_back();
    test_enable_gap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, SHALL set the number of multiplexed digits (legal range 2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the number of clock cycles each digit is held active (legal range >=2).
REQ-003 Parameter ACTIVE_LOW, default 0, SHALL invert every bit of o_7seg and o_digit_en when set to 1 (common-anode boards).
REQ-004 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_en  input  1  SHALL enable scanning; low SHALL blank the display.
REQ-007 i_load  input  1  SHALL be a single-cycle strobe that captures i_value.
REQ-008 i_value  input  4*N_DIGITS  SHALL carry hex nibbles; nibble k drives digit k, and digit 0 is the LSB.
REQ-009 i_blank_lz  input  1  SHALL enable leading-zero blanking when high.
REQ-010 o_7seg  output  7  SHALL be the segment drive, bit order {g,f,e,d,c,b,a}, active high before the ACTIVE_LOW inversion.
REQ-011 o_digit_en  output  N_DIGITS  SHALL be the one-hot digit enable, active high before the ACTIVE_LOW inversion.
REQ-012 o_pending  output  1  SHALL be high while a loaded value waits for the frame boundary.
REQ-013 o_frame  output  1  SHALL pulse for one cycle when the scan wraps from digit N_DIGITS-1 to digit 0.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 while i_en=1, produce a tick at REFRESH_DIV-1, then wrap to 0.
REQ-015 On each tick, the digit index SHALL advance by 1, and SHALL wrap from N_DIGITS-1 to 0.
REQ-016 On the wrap tick, o_frame SHALL be 1 in the following cycle only.
REQ-017 i_load=1 SHALL copy i_value into the pending register and set o_pending in the next cycle.
REQ-018 On the wrap tick with o_pending=1, the pending register SHALL transfer to the display register and o_pending SHALL clear, so frames are never torn.
REQ-019 i_load coincident with the wrap tick SHALL be treated as follows: the old pending value transfers, the new value is captured, and o_pending stays 1.
REQ-020 Repeated i_load before a frame boundary SHALL overwrite the pending value; only the last loaded value SHALL be displayed.
REQ-021 Hex decode (a..g active-high, hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 With i_blank_lz=1, a digit k>0 SHALL be blanked (segments 00) when nibble k and every higher nibble are 0.
REQ-023 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-024 o_7seg and o_digit_en SHALL be registered, each lagging the digit index by exactly 1 cycle.
REQ-025 o_digit_en SHALL have exactly one bit active while i_en=1, and that bit SHALL equal the current index.
REQ-026 While i_en=0:
- prescaler and index SHALL hold;
- o_digit_en SHALL be all inactive and o_7seg SHALL be all off from the next cycle;
- i_load SHALL still capture, but no transfer SHALL occur.
REQ-027 When i_en rises, scanning SHALL resume from the held index and prescaler values.

Reset
REQ-028 While i_rst_n=0, the following SHALL hold immediately regardless of i_clk:
- prescaler, index, pending register, display register = 0;
- o_pending = 0 and o_frame = 0;
- o_digit_en all inactive and o_7seg all off (respecting ACTIVE_LOW).
REQ-029 Reset asserted mid-frame SHALL discard any pending value.
REQ-030 After i_rst_n deasserts with i_en=1, digit 0 SHALL be the first digit enabled.

Verification (N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0)
REQ-031 Release reset, i_en=1, no load -> o_digit_en sequence 0001,0010,0100,1000 at 4 cycles each; o_7seg=3F throughout; o_frame pulses every 16 cycles.
REQ-032 Load 0x12AF mid-frame -> o_pending=1 until the next wrap; the following frame shows digit0=71, digit1=77, digit2=5B, digit3=06.
REQ-033 Load 0x0050 with i_blank_lz=1 -> digits 3 and 2 show 00, digit1=6D, digit0=3F; with i_blank_lz=0, digits 3 and 2 show 3F.
REQ-034 Load 0x1111 then 0x2222 in the same frame -> only 2222 is displayed (5B on all digits); a load on the wrap-tick cycle keeps o_pending=1.
REQ-035 Drop i_en for 10 cycles mid-digit -> outputs blank, index and prescaler frozen, resume on the same digit with the same remaining cycles; repeat with ACTIVE_LOW=1 and check inverted polarity.
REQ-036 Assert i_rst_n=0 asynchronously with o_pending=1 -> all outputs go to reset values before the next clock edge; after release, the old value is not displayed.
